// File: rtl/lc4_muldiv_pkg.sv
// Shared encodings for the LC4 multi-cycle multiply/divide/modulo unit.
package lc4_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MOD  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/lc4_muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and the mul/div unit.
interface lc4_muldiv_unit_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
);
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [TAG_W-1:0] i_tag;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_valid, i_op, i_a, i_b, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag
    );
endinterface

// File: rtl/lc4_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module lc4_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_c,
    output logic             q_c
);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // The trial value is one bit wider than rem so a remainder with its MSB set still compares correctly.
    always_comb begin
        trial = {rem, dbit};
        diff  = trial[WIDTH-1:0] - divisor;
        q_c   = (trial >= {1'b0, divisor});
        rem_c = q_c ? diff : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/lc4_muldiv_unit.sv
// Iterative one-bit-per-cycle MUL/DIV/MOD unit with tagged valid/ready request and response.
module lc4_muldiv_unit
    import lc4_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    lc4_muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             zero_q, zero_d;
    logic             o_ready_q, o_valid_q;
    logic [WIDTH-1:0] o_result_q, o_result_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;

    logic             accept;
    logic             last;
    logic             early;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    assign accept = bus.i_valid && o_ready_q && !bus.i_flush;
    assign last   = (cnt_q == CNT_W'(1));
    assign early  = (bus.i_op == 2'(OP_RSVD)) ||
                    ((bus.i_op != 2'(OP_MUL)) && (bus.i_b == '0));

    lc4_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (acc_q),
        .dbit    (a_q[WIDTH-1]),
        .divisor (b_q),
        .rem_c   (div_rem),
        .q_c     (div_q)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            zero_q     <= 1'b0;
            o_ready_q  <= 1'b1;
            o_valid_q  <= 1'b0;
            o_result_q <= '0;
            o_tag_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            zero_q     <= zero_d;
            o_ready_q  <= (state_d == S_IDLE);
            o_valid_q  <= (state_d == S_DONE);
            o_result_q <= o_result_d;
            o_tag_q    <= o_tag_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (accept)      state_d = S_BUSY;
                S_BUSY:  if (last)        state_d = S_DONE;
                S_DONE:  if (bus.i_ready) state_d = S_IDLE;
                default:                  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        zero_d     = zero_q;
        o_result_d = o_result_q;
        o_tag_d    = o_tag_q;
        if (state_q == S_IDLE && accept) begin
            op_d   = op_e'(bus.i_op);
            a_d    = bus.i_a;
            b_d    = bus.i_b;
            acc_d  = '0;
            tag_d  = bus.i_tag;
            zero_d = early;
            // Early-out ops take a single step so their response lands one edge after accept.
            cnt_d  = early ? CNT_W'(1) : CNT_W'(WIDTH);
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
                if (b_q[0]) acc_d = acc_q + a_q;
                a_d = a_q << 1;
                b_d = b_q >> 1;
            end else begin
                acc_d = div_rem;
                a_d   = {a_q[WIDTH-2:0], div_q};
            end
            if (last && !bus.i_flush) begin
                if (zero_q)              o_result_d = '0;
                else if (op_q == OP_DIV) o_result_d = a_d;
                else                     o_result_d = acc_d;
                o_tag_d = tag_q;
            end
        end
    end

    assign bus.o_ready  = o_ready_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_result = o_result_q;
    assign bus.o_tag    = o_tag_q;
endmodule

// File: tb/tb_lc4_muldiv_unit.sv
// Self-checking bench for lc4_muldiv_unit at WIDTH=16 and WIDTH=8.
module tb_lc4_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lc4_muldiv_unit_if #(.WIDTH(16), .TAG_W(4)) b16 ();
    lc4_muldiv_unit_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

    lc4_muldiv_unit #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    lc4_muldiv_unit #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on unsigned operands.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            2'd0: begin p = a * b; return p[15:0]; end
            2'd1: return (b == 16'd0) ? 16'd0 : 16'(a / b);
            2'd2: return (b == 16'd0) ? 16'd0 : 16'(a % b);
            default: return 16'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [15:0] b);
        return (op == 2'd3 || (op != 2'd0 && b == 16'd0)) ? 1 : 16;
    endfunction

    task automatic wait_ready16();
        int n = 0;
        while (!b16.o_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!b16.o_ready) chk("ready16 timeout", 0, 1);
    endtask

    task automatic accept16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        wait_ready16();
        b16.i_valid = 1'b1; b16.i_op = op; b16.i_a = a; b16.i_b = b; b16.i_tag = tag;
        @(posedge clk); #1;
        b16.i_valid = 1'b0;
        b16.i_op = 2'($urandom); b16.i_a = 16'($urandom); b16.i_b = 16'($urandom);
        b16.i_tag = 4'($urandom);
    endtask

    task automatic run16(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] exp, input int exp_lat, input int hold);
        int n = 0;
        accept16(op, a, b, tag);
        while (!b16.o_valid && n < 40) begin
            chk({name, " busy ready"}, 64'(b16.o_ready), 0);
            @(posedge clk); #1; n++;
        end
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " result"}, b16.o_result, exp);
        chk({name, " tag"}, b16.o_tag, tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " hold"}, {b16.o_valid, b16.o_ready, b16.o_tag, b16.o_result}, {1'b1, 1'b0, tag, exp});
        end
        b16.i_ready = 1'b1;
        @(posedge clk); #1;
        b16.i_ready = 1'b0;
        chk({name, " release"}, {b16.o_valid, b16.o_ready}, 2'b01);
    endtask

    task automatic run8(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp);
        int n = 0;
        while (!b8.o_ready && n < 50) begin @(posedge clk); #1; n++; end
        b8.i_valid = 1'b1; b8.i_op = op; b8.i_a = a; b8.i_b = b; b8.i_tag = 4'd5;
        @(posedge clk); #1;
        b8.i_valid = 1'b0; b8.i_a = 8'h00; b8.i_b = 8'h00;
        n = 0;
        while (!b8.o_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk({name, " latency"}, 64'(n), 8);
        chk({name, " result"}, b8.o_result, exp);
        chk({name, " tag"}, b8.o_tag, 4'd5);
        b8.i_ready = 1'b1;
        @(posedge clk); #1;
        b8.i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        logic [1:0]  rop;
        logic [15:0] ra, rb;

        b16.i_valid = 0; b16.i_op = 0; b16.i_a = 0; b16.i_b = 0; b16.i_tag = 0;
        b16.i_flush = 0; b16.i_ready = 0;
        b8.i_valid = 0; b8.i_op = 0; b8.i_a = 0; b8.i_b = 0; b8.i_tag = 0;
        b8.i_flush = 0; b8.i_ready = 0;

        tbl[0]  = '{2'd0, 16'h0123, 16'h0100, 4'd3,  16'h2300, 16};
        tbl[1]  = '{2'd1, 16'd100,  16'd7,    4'd1,  16'd14,   16};
        tbl[2]  = '{2'd2, 16'd100,  16'd7,    4'd2,  16'd2,    16};
        tbl[3]  = '{2'd1, 16'h1234, 16'h0000, 4'd4,  16'h0000, 1};
        tbl[4]  = '{2'd3, 16'h1234, 16'h5678, 4'd5,  16'h0000, 1};
        tbl[5]  = '{2'd2, 16'h0005, 16'h0000, 4'd6,  16'h0000, 1};
        tbl[6]  = '{2'd0, 16'hFFFF, 16'hFFFF, 4'd7,  16'h0001, 16};
        tbl[7]  = '{2'd1, 16'hFFFF, 16'h0001, 4'd8,  16'hFFFF, 16};
        tbl[8]  = '{2'd2, 16'hFFFF, 16'h8000, 4'd9,  16'h7FFF, 16};
        tbl[9]  = '{2'd2, 16'hFFFE, 16'hFFFF, 4'd10, 16'hFFFE, 16};
        tbl[10] = '{2'd1, 16'hFFFF, 16'h8001, 4'd11, 16'h0001, 16};
        tbl[11] = '{2'd2, 16'hFFFF, 16'h8001, 4'd12, 16'h7FFE, 16};

        #1 rst_n = 1'b0;
        #20;
        chk("reset state", {b16.o_ready, b16.o_valid, b16.o_tag, b16.o_result}, {1'b1, 1'b0, 4'd0, 16'd0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run16($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp, tbl[i].lat, i % 2);

        run16("backpressure mul", 2'd0, 16'd5, 16'd6, 4'd9, 16'd30, 16, 5);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            run16($sformatf("rand%0d", i), rop, ra, rb, 4'(i), model(rop, ra, rb), model_lat(rop, rb),
                  $urandom_range(0, 2));
        end

        // Flush on iteration edge 8 of DIV 1000/3
        accept16(2'd1, 16'd1000, 16'd3, 4'd2);
        repeat (7) begin @(posedge clk); #1; end
        b16.i_flush = 1'b1;
        @(posedge clk); #1;
        b16.i_flush = 1'b0;
        chk("flush busy", {b16.o_valid, b16.o_ready}, 2'b01);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (b16.o_valid) seen = 1'b1; end
        chk("flush no valid", 64'(seen), 0);
        run16("after flush div", 2'd1, 16'd9, 16'd3, 4'd3, 16'd3, 16, 0);

        // Flush in IDLE blocks a simultaneous request
        b16.i_valid = 1'b1; b16.i_flush = 1'b1; b16.i_op = 2'd0; b16.i_a = 16'd2; b16.i_b = 16'd2;
        @(posedge clk); #1;
        b16.i_valid = 1'b0; b16.i_flush = 1'b0;
        chk("flush idle no accept", 64'(b16.o_ready), 1);

        // Flush in DONE discards the pending result
        accept16(2'd0, 16'd7, 16'd7, 4'd1);
        repeat (16) begin @(posedge clk); #1; end
        chk("done before flush", {b16.o_valid, b16.o_result}, {1'b1, 16'd49});
        b16.i_flush = 1'b1;
        @(posedge clk); #1;
        b16.i_flush = 1'b0;
        chk("flush done", {b16.o_valid, b16.o_ready}, 2'b01);

        // Asynchronous reset mid-BUSY
        run16("pre reset", 2'd0, 16'd3, 16'd5, 4'd6, 16'd15, 16, 0);
        accept16(2'd0, 16'd11, 16'd13, 4'd7);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", {b16.o_ready, b16.o_valid, b16.o_tag, b16.o_result}, {1'b1, 1'b0, 4'd0, 16'd0});
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run16("post reset", 2'd0, 16'd3, 16'd4, 4'd8, 16'd12, 16, 0);

        run8("w8 div", 2'd1, 8'hFF, 8'h10, 8'h0F);
        run8("w8 mod", 2'd2, 8'hFF, 8'h10, 8'h0F);
        run8("w8 mul", 2'd0, 8'h13, 8'h11, 8'h43);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
